usb_line_state_detector: RTL and testbench
==========================================

Name: usb_line_state_detector

Overview:
- Parametrised successor to the receive-side EOP detector, sitting between the D+/D- synchronisers and the receive control FSM.
- Classifies the bus line state once per bit time and detects valid EOP (SE0 for at least SE0_EOP_BITS bits, then J).
- Also detects malformed EOP, SE1, and USB bus reset (SE0 held for RESET_BITS bits).
- Supports full-speed and low-speed J/K polarity. Reports a sticky error code to the receive controller.

Parameters:
- SE0_EOP_BITS, 2: minimum consecutive SE0 bit samples that qualify an EOP (legal range 1..15).
- RESET_BITS, 30: consecutive SE0 bit samples that declare bus reset (must exceed SE0_EOP_BITS; max 255).
- LOW_SPEED, 0: 0 means J = (D+,D-) = (1,0); 1 means J = (0,1).
- Derived localparam CNT_W = $clog2(RESET_BITS+1).

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset
- shift_enable  in  1  one-clk strobe at bit centre; line is sampled only on this strobe
- d_plus_sync  in  1  synchronised D+
- d_minus_sync  in  1  synchronised D-
- eop  out  1  one-clk pulse: valid EOP completed
- eop_err  out  1  one-clk pulse: malformed EOP or SE1
- bus_reset  out  1  level: high while bus reset is in progress
- se0_active  out  1  level: high while FSM is counting SE0
- err_code  out  2  sticky status: 0 none, 1 short SE0, 2 bad terminator (K after SE0), 3 SE1
- Reset: n_rst is asynchronous, active-low; clock is clk.

Behaviour:
- Reset values: state IDLE, count 0, eop 0, eop_err 0, bus_reset 0, se0_active 0, err_code 0.
- A reset asserted mid-operation aborts immediately to these values.
- Line decode (combinational, per sample): SE0 = 00; SE1 = 11; J and K follow LOW_SPEED polarity.
- Without shift_enable, the FSM and count hold their values.
- States: IDLE, SE0_CNT, EOP, ERR, BUS_RST.
- IDLE:
  - strobe and SE0: go to SE0_CNT, count = 1.
  - strobe and SE1: go to ERR (code 3), only when SE1_DETECT_EN is defined.
  - otherwise stay in IDLE.
- SE0_CNT (se0_active = 1), on strobe:
  - SE0: count += 1. When the new count equals RESET_BITS, go to BUS_RST.
  - J: if count >= SE0_EOP_BITS, go to EOP; else go to ERR (code 1).
  - K: go to ERR (code 2).
  - SE1: go to ERR (code 3) if SE1_DETECT_EN is defined; otherwise treat as K.
- EOP: stays exactly 1 clk, then IDLE. eop = 1 in this state. err_code clears to 0 on entry.
- ERR: stays exactly 1 clk, then IDLE. eop_err = 1 in this state. err_code is loaded on entry and held until the next EOP or bus reset.
- BUS_RST:
  - bus_reset = 1; err_code clears to 0 on entry; count saturates (no wrap).
  - Leaves to IDLE on a strobe sampling non-SE0.
  - No eop pulse is generated on exit.
- Latency: eop and eop_err assert on the clk after the strobe that sampled the terminating symbol.
- Outputs are Moore, decoded from registered state, so they are glitch-free.
- Simultaneous events:
  - A strobe during the single EOP or ERR cycle is ignored; the next strobe is evaluated from IDLE.
  - Back-to-back SE0 immediately after EOP therefore starts a new count from 1 on the following strobe.

Optional Feature:
- Macro SE1_DETECT_EN.
- Defined: SE1 samples in IDLE or SE0_CNT raise ERR with err_code 3.
- Undefined: SE1 is treated as K. In SE0_CNT it gives code 2; in IDLE it is ignored. err_code 3 is never produced.

Decomposition:
- Package usb_rx_pkg holds:
  - line_t enum {LS_SE0, LS_J, LS_K, LS_SE1}
  - det_state_t enum {IDLE, SE0_CNT, EOP, ERR, BUS_RST}
  - err_code_t enum {ERR_NONE, ERR_SHORT_SE0, ERR_BAD_TERM, ERR_SE1}
- One sub-module: usb_line_decode (parameter LOW_SPEED; inputs d_plus_sync, d_minus_sync; output line_t).
- The detector instantiates usb_line_decode plus its FSM and counter.

Test Plan:
- Defaults; strobes sample SE0, SE0, J: eop pulses 1 clk after the J strobe; err_code = 0; eop_err never asserts.
- SE0, then J on the next strobe (count 1 < 2): eop_err pulses once, err_code = 1, eop stays 0; a following valid EOP clears err_code to 0.
- SE0, SE0, K: eop_err pulses, err_code = 2.
- 30 consecutive SE0 strobes: bus_reset rises 1 clk after the 30th strobe. Hold 40 strobes: bus_reset stays 1 with no wrap. A J strobe then drops bus_reset, with no eop.
- LOW_SPEED=1: SE0, SE0, (0,1) gives eop; SE0, SE0, (1,0) gives err_code 2.
- SE1 in IDLE: with SE1_DETECT_EN, eop_err pulses and err_code = 3; without it, no response. Also assert n_rst mid-count after 10 SE0 strobes: all outputs return to 0 immediately.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive path.
//   line_t      : decoded bus line state for one bit sample
//   det_state_t : line-state detector FSM states
//   err_code_t  : sticky error code reported to the receive controller
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0,
    LS_J,
    LS_K,
    LS_SE1
  } line_t;

  typedef enum logic [2:0] {
    IDLE,
    SE0_CNT,
    EOP,
    ERR,
    BUS_RST
  } det_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SHORT_SE0,
    ERR_BAD_TERM,
    ERR_SE1
  } err_code_t;

endpackage

// File: rtl/usb_line_decode.sv
// Combinational USB line-state decoder.
// Parameters:
//   LOW_SPEED    : 0 -> J = (D+,D-) = (1,0); 1 -> J = (0,1)
// Ports:
//   d_plus_sync  in  synchronised D+
//   d_minus_sync in  synchronised D-
//   line_state   out decoded line state (SE0, J, K, SE1)
module usb_line_decode
  import usb_rx_pkg::*;
#(
  parameter int unsigned LOW_SPEED = 0
) (
  input  logic  d_plus_sync,
  input  logic  d_minus_sync,
  output line_t line_state
);

  always_comb begin
    line_state = LS_SE0;
    unique case ({d_plus_sync, d_minus_sync})
      2'b00:   line_state = LS_SE0;
      2'b11:   line_state = LS_SE1;
      2'b10:   line_state = (LOW_SPEED != 0) ? LS_K : LS_J;
      2'b01:   line_state = (LOW_SPEED != 0) ? LS_J : LS_K;
      default: line_state = LS_SE0;
    endcase
  end

endmodule

// File: rtl/usb_line_state_detector.sv
// Receive-side USB line-state detector: classifies the bus once per bit time and
// reports valid EOP, malformed EOP / SE1, and bus reset.
// Optional build macro: SE1_DETECT_EN -- when defined, SE1 in IDLE or SE0_CNT raises
// an error with code 3; otherwise SE1 is treated as K.
// Parameters:
//   SE0_EOP_BITS : min SE0 bit samples qualifying an EOP (1..15)
//   RESET_BITS   : SE0 bit samples declaring bus reset (> SE0_EOP_BITS, <= 255)
//   LOW_SPEED    : J/K polarity select
// Ports:
//   clk          in  system clock
//   n_rst        in  asynchronous active-low reset
//   shift_enable in  one-clk strobe at bit centre; line sampled only here
//   d_plus_sync  in  synchronised D+
//   d_minus_sync in  synchronised D-
//   eop          out one-clk pulse, valid EOP completed
//   eop_err      out one-clk pulse, malformed EOP or SE1
//   bus_reset    out level, bus reset in progress
//   se0_active   out level, counting SE0
//   err_code     out sticky status (0 none, 1 short SE0, 2 bad terminator, 3 SE1)
module usb_line_state_detector
  import usb_rx_pkg::*;
#(
  parameter int unsigned SE0_EOP_BITS = 2,
  parameter int unsigned RESET_BITS   = 30,
  parameter int unsigned LOW_SPEED    = 0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       shift_enable,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  output logic       eop,
  output logic       eop_err,
  output logic       bus_reset,
  output logic       se0_active,
  output logic [1:0] err_code
);

  localparam int unsigned CNT_W = $clog2(RESET_BITS + 1);
  localparam logic [CNT_W-1:0] EopMinCnt = CNT_W'(SE0_EOP_BITS);
  localparam logic [CNT_W-1:0] RstCnt    = CNT_W'(RESET_BITS);

  line_t            w_line;
  det_state_t       r_state, w_state_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  err_code_t        r_err_code, w_err_code_d;

  usb_line_decode #(
    .LOW_SPEED(LOW_SPEED)
  ) u_line_decode (
    .d_plus_sync (d_plus_sync),
    .d_minus_sync(d_minus_sync),
    .line_state  (w_line)
  );

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_err_code_d = r_err_code;
    unique case (r_state)
      IDLE: begin
        if (shift_enable) begin
          if (w_line == LS_SE0) begin
            w_state_d = SE0_CNT;
            w_count_d = CNT_W'(1);
          end
`ifdef SE1_DETECT_EN
          else if (w_line == LS_SE1) begin
            w_state_d    = ERR;
            w_err_code_d = ERR_SE1;
          end
`endif
        end
      end
      SE0_CNT: begin
        if (shift_enable) begin
          unique case (w_line)
            LS_SE0: begin
              // Count never exceeds RESET_BITS-1 here, so the increment cannot wrap.
              w_count_d = r_count + 1'b1;
              if (w_count_d == RstCnt) begin
                w_state_d    = BUS_RST;
                w_err_code_d = ERR_NONE;
              end
            end
            LS_J: begin
              if (r_count >= EopMinCnt) begin
                w_state_d    = EOP;
                w_err_code_d = ERR_NONE;
              end else begin
                w_state_d    = ERR;
                w_err_code_d = ERR_SHORT_SE0;
              end
            end
            LS_K: begin
              w_state_d    = ERR;
              w_err_code_d = ERR_BAD_TERM;
            end
            LS_SE1: begin
              w_state_d = ERR;
`ifdef SE1_DETECT_EN
              w_err_code_d = ERR_SE1;
`else
              w_err_code_d = ERR_BAD_TERM;
`endif
            end
            default: begin
              w_state_d = IDLE;
              w_count_d = '0;
            end
          endcase
        end
      end
      // Single-cycle pulse states; any strobe landing here is deliberately dropped.
      EOP, ERR: begin
        w_state_d = IDLE;
        w_count_d = '0;
      end
      BUS_RST: begin
        // Count stays parked at RESET_BITS while SE0 persists.
        if (shift_enable && (w_line != LS_SE0)) begin
          w_state_d = IDLE;
          w_count_d = '0;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_d;
      r_count    <= w_count_d;
      r_err_code <= w_err_code_d;
    end
  end

  assign eop        = (r_state == EOP);
  assign eop_err    = (r_state == ERR);
  assign bus_reset  = (r_state == BUS_RST);
  assign se0_active = (r_state == SE0_CNT);
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_usb_line_state_detector.sv
// Bench for usb_line_state_detector: a full-speed instance (dut0) and a low-speed
// instance (dut1) share stimulus. Observations are packed as
// {eop, eop_err, bus_reset, se0_active, err_code}.
module tb_usb_line_state_detector;

  logic clk = 1'b0;
  logic n_rst;
  logic shift_enable;
  logic d_plus_sync;
  logic d_minus_sync;

  logic       eop0, eop_err0, bus_reset0, se0_active0;
  logic [1:0] err_code0;
  logic       eop1, eop_err1, bus_reset1, se0_active1;
  logic [1:0] err_code1;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];

`ifdef SE1_DETECT_EN
  localparam bit SE1_ON = 1'b1;
`else
  localparam bit SE1_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  usb_line_state_detector #(
    .SE0_EOP_BITS(2),
    .RESET_BITS  (30),
    .LOW_SPEED   (0)
  ) dut0 (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_enable),
    .d_plus_sync (d_plus_sync),
    .d_minus_sync(d_minus_sync),
    .eop         (eop0),
    .eop_err     (eop_err0),
    .bus_reset   (bus_reset0),
    .se0_active  (se0_active0),
    .err_code    (err_code0)
  );

  usb_line_state_detector #(
    .SE0_EOP_BITS(2),
    .RESET_BITS  (30),
    .LOW_SPEED   (1)
  ) dut1 (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_enable),
    .d_plus_sync (d_plus_sync),
    .d_minus_sync(d_minus_sync),
    .eop         (eop1),
    .eop_err     (eop_err1),
    .bus_reset   (bus_reset1),
    .se0_active  (se0_active1),
    .err_code    (err_code1)
  );

  function automatic logic [5:0] mk(input bit e, input bit ee, input bit br, input bit sa,
                                     input logic [1:0] c);
    return {e, ee, br, sa, c};
  endfunction

  function automatic logic [5:0] obs(input bit sel);
    if (sel) return {eop1, eop_err1, bus_reset1, se0_active1, err_code1};
    return {eop0, eop_err0, bus_reset0, se0_active0, err_code0};
  endfunction

  // One strobe sampling sym, observed just after its edge (a) and one clk later (b).
  task automatic spaced(input logic [1:0] sym, input bit sel, output logic [5:0] a,
                        output logic [5:0] b);
    @(negedge clk);
    {d_plus_sync, d_minus_sync} = sym;
    shift_enable = 1'b1;
    @(posedge clk);
    #1 a = obs(sel);
    @(negedge clk);
    shift_enable = 1'b0;
    @(posedge clk);
    #1 b = obs(sel);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    shift_enable = 1'b0;
    {d_plus_sync, d_minus_sync} = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs(s[0]) !== 6'b0) begin
        errors++;
        $display("FAIL reset dut%0d got %b want %b", s, obs(s[0]), 6'b0);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_low_speed();
    logic [1:0] syms[6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [5:0] a, b, e;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        sb.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(mk(0, 0, 0, 0, 0));
      end else if (i == 5) begin
        sb.push_back(mk(0, 1, 0, 0, 2)); sb.push_back(mk(0, 0, 0, 0, 2));
      end else begin
        sb.push_back(mk(0, 0, 0, 1, 0)); sb.push_back(mk(0, 0, 0, 1, 0));
      end
      spaced(syms[i], 1'b1, a, b);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL low_speed step %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL low_speed_hold step %0d got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_valid_eop();
    logic [1:0] syms[3] = '{2'b00, 2'b00, 2'b10};
    logic [5:0] a, b, e;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        sb.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(mk(0, 0, 0, 0, 0));
      end else begin
        sb.push_back(mk(0, 0, 0, 1, 0)); sb.push_back(mk(0, 0, 0, 1, 0));
      end
      spaced(syms[i], 1'b0, a, b);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL valid_eop step %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL valid_eop_hold step %0d got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_short_se0();
    logic [1:0] syms[5] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
    logic [5:0] a, b, e;
    sb.push_back(mk(0, 0, 0, 1, 0)); sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(0, 1, 0, 0, 1)); sb.push_back(mk(0, 0, 0, 0, 1));
    sb.push_back(mk(0, 0, 0, 1, 1)); sb.push_back(mk(0, 0, 0, 1, 1));
    sb.push_back(mk(0, 0, 0, 1, 1)); sb.push_back(mk(0, 0, 0, 1, 1));
    sb.push_back(mk(1, 0, 0, 0, 0)); sb.push_back(mk(0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      spaced(syms[i], 1'b0, a, b);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL short_se0 step %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL short_se0_hold step %0d got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_bad_term();
    logic [1:0] syms[3] = '{2'b00, 2'b00, 2'b01};
    logic [5:0] a, b, e;
    sb.push_back(mk(0, 0, 0, 1, 0)); sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(0, 0, 0, 1, 0)); sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(0, 1, 0, 0, 2)); sb.push_back(mk(0, 0, 0, 0, 2));
    for (int i = 0; i < 3; i++) begin
      spaced(syms[i], 1'b0, a, b);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL bad_term step %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL bad_term_hold step %0d got %b want %b", i, b, e); end
    end
  endtask

  // Enters with err_code 2 held; bus reset must clear it.
  task automatic test_bus_reset();
    logic [5:0] a, b, e;
    for (int i = 1; i <= 71; i++) begin
      if (i < 30) begin
        sb.push_back(mk(0, 0, 0, 1, 2)); sb.push_back(mk(0, 0, 0, 1, 2));
        spaced(2'b00, 1'b0, a, b);
      end else if (i <= 70) begin
        sb.push_back(mk(0, 0, 1, 0, 0)); sb.push_back(mk(0, 0, 1, 0, 0));
        spaced(2'b00, 1'b0, a, b);
      end else begin
        sb.push_back(mk(0, 0, 0, 0, 0)); sb.push_back(mk(0, 0, 0, 0, 0));
        spaced(2'b10, 1'b0, a, b);
      end
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL bus_reset strobe %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL bus_reset_hold strobe %0d got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_se1();
    logic [1:0] syms[3] = '{2'b11, 2'b00, 2'b11};
    logic [1:0] c;
    logic [5:0] a, b, e;
    c = SE1_ON ? 2'd3 : 2'd0;
    if (SE1_ON) begin
      sb.push_back(mk(0, 1, 0, 0, 3)); sb.push_back(mk(0, 0, 0, 0, 3));
    end else begin
      sb.push_back(mk(0, 0, 0, 0, 0)); sb.push_back(mk(0, 0, 0, 0, 0));
    end
    sb.push_back(mk(0, 0, 0, 1, c)); sb.push_back(mk(0, 0, 0, 1, c));
    if (SE1_ON) begin
      sb.push_back(mk(0, 1, 0, 0, 3)); sb.push_back(mk(0, 0, 0, 0, 3));
    end else begin
      sb.push_back(mk(0, 1, 0, 0, 2)); sb.push_back(mk(0, 0, 0, 0, 2));
    end
    for (int i = 0; i < 3; i++) begin
      spaced(syms[i], 1'b0, a, b);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL se1 step %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL se1_hold step %0d got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] c;
    logic [5:0] a, b, e;
    c = SE1_ON ? 2'd3 : 2'd2;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(mk(0, 0, 0, 1, c)); sb.push_back(mk(0, 0, 0, 1, c));
      spaced(2'b00, 1'b0, a, b);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_mid count %0d got %b want %b", i, a, e); end
      e = sb.pop_front(); checks++;
      if (b !== e) begin errors++; $display("FAIL reset_mid_hold %0d got %b want %b", i, b, e); end
    end
    // Assert reset between clock edges; outputs must clear without waiting for a clock.
    #2 n_rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (obs(s[0]) !== 6'b0) begin
        errors++;
        $display("FAIL reset_mid_async dut%0d got %b want %b", s, obs(s[0]), 6'b0);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Strobe every clk: the strobe landing in the EOP cycle is dropped, so the next
  // SE0 starts from count 1 and a following J is a short SE0.
  task automatic test_back_to_back();
    logic [1:0] syms[6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
    logic [5:0] a, e;
    sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(0, 1, 0, 0, 1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {d_plus_sync, d_minus_sync} = syms[i];
      shift_enable = 1'b1;
      @(posedge clk);
      #1 a = obs(1'b0);
      e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL back_to_back step %0d got %b want %b", i, a, e); end
    end
    @(negedge clk);
    shift_enable = 1'b0;
    {d_plus_sync, d_minus_sync} = 2'b10;
  endtask

  initial begin
    test_reset();
    test_low_speed();
    test_valid_eop();
    test_short_se0();
    test_bad_term();
    test_bus_reset();
    test_se1();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
